// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// master drives operands and result acceptance; slave is the subtractor itself.
interface serial_subtractor_if #(
    parameter int DATA_WIDTH = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic                  bin;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] diff;
    logic                  bout;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one bit per clock,
// with valid/ready handshakes on both the operand and result sides.
module serial_subtractor #(
    parameter int DATA_WIDTH = 4
) (
    input logic                clk,
    input logic                rst,
    serial_subtractor_if.slave bus
);
    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    logic [CW-1:0]         cnt_reg, cnt_next;
    logic [DATA_WIDTH-1:0] a_sr_reg, a_sr_next;
    logic [DATA_WIDTH-1:0] b_sr_reg, b_sr_next;
    logic [DATA_WIDTH-1:0] res_sr_reg, res_sr_next;
    logic                  borrow_reg, borrow_next;
    logic [DATA_WIDTH-1:0] diff_reg, diff_next;
    logic                  bout_reg, bout_next;

    logic                  x_bit;
    logic                  y_bit;
    logic                  d_bit;
    logic                  borrow_new;
    logic                  last_bit;
    logic [DATA_WIDTH-1:0] res_shifted;

    // One full-subtractor cell operating on the current LSBs.
    assign x_bit      = a_sr_reg[0];
    assign y_bit      = b_sr_reg[0];
    assign d_bit      = x_bit ^ y_bit ^ borrow_reg;
    assign borrow_new = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & borrow_reg);
    assign last_bit   = (cnt_reg == CW'(DATA_WIDTH - 1));

    // Result register shifts right with the new bit entering at the MSB, so
    // after DATA_WIDTH steps bit 0 holds the first (LSB) difference bit.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH - 1; gi++) begin : g_res_shift
            assign res_shifted[gi] = res_sr_reg[gi+1];
        end
    endgenerate
    assign res_shifted[DATA_WIDTH-1] = d_bit;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        a_sr_next   = a_sr_reg;
        b_sr_next   = b_sr_reg;
        res_sr_next = res_sr_reg;
        borrow_next = borrow_reg;
        diff_next   = diff_reg;
        bout_next   = bout_reg;

        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    a_sr_next   = bus.a;
                    b_sr_next   = bus.b;
                    borrow_next = bus.bin;
                    res_sr_next = '0;
                    cnt_next    = '0;
                    state_next  = RUN;
                end
            end
            RUN: begin
                a_sr_next   = a_sr_reg >> 1;
                b_sr_next   = b_sr_reg >> 1;
                borrow_next = borrow_new;
                res_sr_next = res_shifted;
                cnt_next    = cnt_reg + CW'(1);
                if (last_bit) begin
                    // Only the completed word is published; partial bits stay internal.
                    diff_next  = res_shifted;
                    bout_next  = borrow_new;
                    cnt_next   = '0;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            a_sr_reg   <= '0;
            b_sr_reg   <= '0;
            res_sr_reg <= '0;
            borrow_reg <= 1'b0;
            diff_reg   <= '0;
            bout_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            a_sr_reg   <= a_sr_next;
            b_sr_reg   <= b_sr_next;
            res_sr_reg <= res_sr_next;
            borrow_reg <= borrow_next;
            diff_reg   <= diff_next;
            bout_reg   <= bout_next;
        end
    end

    assign bus.in_ready  = (state_reg == IDLE) && !rst;
    assign bus.out_valid = (state_reg == DONE);
    assign bus.diff      = diff_reg;
    assign bus.bout      = bout_reg;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomised checks of serial_subtractor at widths 1, 4 and 8.
module tb_serial_subtractor;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    serial_subtractor_if #(.DATA_WIDTH(1)) if1 ();
    serial_subtractor_if #(.DATA_WIDTH(4)) if4 ();
    serial_subtractor_if #(.DATA_WIDTH(8)) if8 ();

    serial_subtractor #(.DATA_WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    serial_subtractor #(.DATA_WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
    serial_subtractor #(.DATA_WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int w, input int unsigned a, input int unsigned b,
                           input int unsigned bin, input logic valid);
        case (w)
            1: begin if1.a = a[0:0]; if1.b = b[0:0]; if1.bin = bin[0]; if1.in_valid = valid; end
            4: begin if4.a = a[3:0]; if4.b = b[3:0]; if4.bin = bin[0]; if4.in_valid = valid; end
            default: begin if8.a = a[7:0]; if8.b = b[7:0]; if8.bin = bin[0]; if8.in_valid = valid; end
        endcase
    endtask

    task automatic set_out_ready(input int w, input logic r);
        case (w)
            1: if1.out_ready = r;
            4: if4.out_ready = r;
            default: if8.out_ready = r;
        endcase
    endtask

    task automatic get_outs(input int w, output logic ov, output logic ir,
                            output int unsigned df, output logic bo);
        case (w)
            1: begin ov = if1.out_valid; ir = if1.in_ready; df = {31'd0, if1.diff}; bo = if1.bout; end
            4: begin ov = if4.out_valid; ir = if4.in_ready; df = {28'd0, if4.diff}; bo = if4.bout; end
            default: begin ov = if8.out_valid; ir = if8.in_ready; df = {24'd0, if8.diff}; bo = if8.bout; end
        endcase
    endtask

    // Drives one W=4 operation and returns the number of edges until out_valid.
    task automatic run_op4(input logic [3:0] a, input logic [3:0] b, input logic bin,
                           output int lat);
        if4.a = a; if4.b = b; if4.bin = bin; if4.in_valid = 1'b1;
        tick();
        if4.in_valid = 1'b0;
        lat = 0;
        while (!if4.out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (if4.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", if4.in_ready); end
        checks++; if (if4.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", if4.out_valid); end
        checks++; if (if4.diff !== 4'h0) begin errors++; $display("FAIL reset_diff: got %h expected 0", if4.diff); end
        checks++; if (if4.bout !== 1'b0) begin errors++; $display("FAIL reset_bout: got %b expected 0", if4.bout); end
        rst = 1'b0;
        #1;
        checks++; if (if4.in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready: got %b expected 1", if4.in_ready); end
        $display("reset: checked idle state after reset");
    endtask

    task automatic test_basic();
        int lat;
        if4.out_ready = 1'b1;
        run_op4(4'b1010, 4'b0110, 1'b1, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency: got %0d expected 4", lat); end
        checks++; if (if4.diff !== 4'b0011) begin errors++; $display("FAIL basic_diff: got %b expected 0011", if4.diff); end
        checks++; if (if4.bout !== 1'b0) begin errors++; $display("FAIL basic_bout: got %b expected 0", if4.bout); end
        $display("basic: 1010-0110-1 -> diff=%b bout=%b latency=%0d", if4.diff, if4.bout, lat);
        tick();
    endtask

    task automatic test_wrap();
        int lat;
        if4.out_ready = 1'b1;
        run_op4(4'b0000, 4'b0001, 1'b0, lat);
        checks++; if (if4.diff !== 4'b1111) begin errors++; $display("FAIL wrap1_diff: got %b expected 1111", if4.diff); end
        checks++; if (if4.bout !== 1'b1) begin errors++; $display("FAIL wrap1_bout: got %b expected 1", if4.bout); end
        $display("wrap: 0000-0001-0 -> diff=%b bout=%b", if4.diff, if4.bout);
        tick();
        run_op4(4'b0110, 4'b1010, 1'b1, lat);
        checks++; if (if4.diff !== 4'b1011) begin errors++; $display("FAIL wrap2_diff: got %b expected 1011", if4.diff); end
        checks++; if (if4.bout !== 1'b1) begin errors++; $display("FAIL wrap2_bout: got %b expected 1", if4.bout); end
        $display("wrap: 0110-1010-1 -> diff=%b bout=%b", if4.diff, if4.bout);
        tick();
        run_op4(4'b0000, 4'b0000, 1'b1, lat);
        checks++; if (if4.diff !== 4'b1111) begin errors++; $display("FAIL wrap3_diff: got %b expected 1111", if4.diff); end
        checks++; if (if4.bout !== 1'b1) begin errors++; $display("FAIL wrap3_bout: got %b expected 1", if4.bout); end
        tick();
        run_op4(4'b1001, 4'b1001, 1'b0, lat);
        checks++; if (if4.diff !== 4'b0000) begin errors++; $display("FAIL equal_diff: got %b expected 0000", if4.diff); end
        checks++; if (if4.bout !== 1'b0) begin errors++; $display("FAIL equal_bout: got %b expected 0", if4.bout); end
        $display("equal: 1001-1001-0 -> diff=%b bout=%b", if4.diff, if4.bout);
        tick();
    endtask

    task automatic test_backpressure();
        int lat;
        if4.out_ready = 1'b0;
        run_op4(4'b1100, 4'b0011, 1'b0, lat);
        checks++; if (if4.out_valid !== 1'b1) begin errors++; $display("FAIL bp_timeout: got %b expected 1", if4.out_valid); end
        for (int c = 0; c < 3; c++) begin
            checks++; if (if4.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid: got %b expected 1", if4.out_valid); end
            checks++; if (if4.diff !== 4'b1001) begin errors++; $display("FAIL bp_diff: got %b expected 1001", if4.diff); end
            checks++; if (if4.bout !== 1'b0) begin errors++; $display("FAIL bp_bout: got %b expected 0", if4.bout); end
            checks++; if (if4.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0", if4.in_ready); end
            if (c == 1) begin
                if4.a = 4'hF; if4.b = 4'h0; if4.bin = 1'b0; if4.in_valid = 1'b1;
            end
            tick();
            if4.in_valid = 1'b0;
        end
        if4.out_ready = 1'b1;
        tick();
        if4.out_ready = 1'b0;
        checks++; if (if4.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b expected 0", if4.out_valid); end
        checks++; if (if4.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", if4.in_ready); end
        checks++; if (if4.diff !== 4'b1001) begin errors++; $display("FAIL bp_diff_held: got %b expected 1001", if4.diff); end
        for (int c = 0; c < 6; c++) tick();
        checks++; if (if4.out_valid !== 1'b0) begin errors++; $display("FAIL bp_ignored_pulse: got %b expected 0", if4.out_valid); end
        $display("backpressure: held diff=%b for 3 cycles, released to idle", if4.diff);
    endtask

    task automatic test_reset_abort();
        int lat;
        logic seen;
        if4.out_ready = 1'b1;
        if4.a = 4'b0111; if4.b = 4'b0010; if4.bin = 1'b0; if4.in_valid = 1'b1;
        tick();
        if4.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        checks++; if (if4.out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid: got %b expected 0", if4.out_valid); end
        checks++; if (if4.diff !== 4'h0) begin errors++; $display("FAIL abort_diff: got %h expected 0", if4.diff); end
        checks++; if (if4.bout !== 1'b0) begin errors++; $display("FAIL abort_bout: got %b expected 0", if4.bout); end
        rst = 1'b0;
        #1;
        checks++; if (if4.in_ready !== 1'b1) begin errors++; $display("FAIL abort_idle: got %b expected 1", if4.in_ready); end
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (if4.out_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_result: got %b expected 0", seen); end
        run_op4(4'b0101, 4'b0011, 1'b1, lat);
        checks++; if (if4.diff !== 4'b0001) begin errors++; $display("FAIL abort_next_diff: got %b expected 0001", if4.diff); end
        checks++; if (if4.bout !== 1'b0) begin errors++; $display("FAIL abort_next_bout: got %b expected 0", if4.bout); end
        $display("reset_abort: aborted op, next 0101-0011-1 -> diff=%b bout=%b", if4.diff, if4.bout);
        tick();
    endtask

    task automatic test_back_to_back();
        int acc[2];
        logic [3:0] rd[2];
        logic rb[2];
        int nacc, nres, npulse;
        logic accepted;
        nacc = 0; nres = 0; npulse = 0;
        if4.out_ready = 1'b1;
        if4.a = 4'b1111; if4.b = 4'b0001; if4.bin = 1'b0; if4.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            accepted = 1'b0;
            if (if4.out_valid && nres < 2) begin
                rd[nres] = if4.diff; rb[nres] = if4.bout; nres++;
            end
            if (if4.in_ready) npulse++;
            if (if4.in_ready && if4.in_valid && nacc < 2) begin
                acc[nacc] = i; nacc++; accepted = 1'b1;
            end
            tick();
            if (accepted) begin
                if (nacc == 1) begin
                    if4.a = 4'b0011; if4.b = 4'b0100; if4.bin = 1'b0;
                end else begin
                    if4.in_valid = 1'b0;
                end
            end
        end
        checks++; if (nacc !== 2) begin errors++; $display("FAIL b2b_accepts: got %0d expected 2", nacc); end
        checks++; if (nres !== 2) begin errors++; $display("FAIL b2b_results: got %0d expected 2", nres); end
        if (nacc == 2) begin
            checks++; if (acc[1] - acc[0] !== 6) begin errors++; $display("FAIL b2b_period: got %0d expected 6", acc[1] - acc[0]); end
        end
        if (nres == 2) begin
            checks++; if (rd[0] !== 4'b1110 || rb[0] !== 1'b0) begin errors++; $display("FAIL b2b_first: got diff=%b bout=%b expected diff=1110 bout=0", rd[0], rb[0]); end
            checks++; if (rd[1] !== 4'b1111 || rb[1] !== 1'b1) begin errors++; $display("FAIL b2b_second: got diff=%b bout=%b expected diff=1111 bout=1", rd[1], rb[1]); end
        end
        $display("back_to_back: %0d accepts, %0d results, %0d in_ready cycles", nacc, nres, npulse);
    endtask

    task automatic test_random(input int w);
        int unsigned a, b, bin, mask, full, ed, eb, df;
        logic ov, ir, bo;
        int n, werr;
        mask = (32'd1 << w) - 1;
        werr = errors;
        set_out_ready(w, 1'b1);
        for (int k = 0; k < 1000; k++) begin
            a = $urandom & mask;
            b = $urandom & mask;
            bin = $urandom_range(0, 1);
            full = (a - b - bin) & ((32'd1 << (w + 1)) - 1);
            ed = full & mask;
            eb = (full >> w) & 1;
            get_outs(w, ov, ir, df, bo);
            checks++; if (ir !== 1'b1) begin errors++; $display("FAIL rand_w%0d_in_ready: got %b expected 1", w, ir); end
            set_ops(w, a, b, bin, 1'b1);
            tick();
            set_ops(w, a, b, bin, 1'b0);
            n = 0;
            get_outs(w, ov, ir, df, bo);
            while (!ov && n < w + 4) begin
                tick();
                n++;
                get_outs(w, ov, ir, df, bo);
            end
            checks++; if (n !== w) begin errors++; $display("FAIL rand_w%0d_latency: got %0d expected %0d", w, n, w); end
            checks++; if (df !== ed) begin errors++; $display("FAIL rand_w%0d_diff: a=%0h b=%0h bin=%0d got %0h expected %0h", w, a, b, bin, df, ed); end
            checks++; if (int'(bo) !== eb) begin errors++; $display("FAIL rand_w%0d_bout: a=%0h b=%0h bin=%0d got %0d expected %0d", w, a, b, bin, bo, eb); end
            checks++; if (df + b + bin !== a + (int'(bo) << w)) begin errors++; $display("FAIL rand_w%0d_identity: diff+b+bin=%0d a+bout*2^W=%0d", w, df + b + bin, a + (int'(bo) << w)); end
            tick();
        end
        set_out_ready(w, 1'b0);
        $display("random W=%0d: 1000 operations, %0d errors", w, errors - werr);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        set_ops(1, 0, 0, 0, 1'b0); set_out_ready(1, 1'b0);
        set_ops(4, 0, 0, 0, 1'b0); set_out_ready(4, 1'b0);
        set_ops(8, 0, 0, 0, 1'b0); set_out_ready(8, 1'b0);
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        tick();
        test_random(1);
        test_random(4);
        test_random(8);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
